// File: rtl/fc_argmax_engine.sv
// -----------------------------------------------------------------------------
// fc_argmax_engine
//
// Fully-connected classifier layer. Consumes one activation per accepted beat,
// updates OUT_DIM dot-product accumulators in parallel, and starts each frame
// from the bias. Once the frame is complete, it streams the OUT_DIM logits
// under ready/valid backpressure and reports the argmax class.
//
// Weight and bias images are passed as packed parameters. The build flow
// produces them from the hex images.
//   W_INIT : weight w[j][k] at slice index j*IN_DIM+k, WGT_W bits each, signed
//   B_INIT : bias b[j] at slice index j, ACC_W bits each, signed
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset; aborts any frame in flight
//   in_data_i     activation k of the current frame
//   in_valid_i    in_data_i valid
//   in_last_i     upstream marker for activation IN_DIM-1 (checked only)
//   in_ready_o    block accepts in_data_i (idle / accumulating)
//   out_data_o    signed logit for class out_idx_o
//   out_idx_o     class index of out_data_o
//   out_valid_o   logit valid
//   out_ready_i   downstream accepts logit
//   class_out_o   argmax index (lowest index wins ties)
//   class_value_o maximum logit
//   class_valid_o one-cycle pulse, class result valid
//   frame_err_o   one-cycle pulse, in_last_i disagreed with the beat counter
//
// Assumes ACC_W+1 >= DATA_W+WGT_W+1 so that a product always fits the adder.
// -----------------------------------------------------------------------------
module fc_argmax_engine #(
   parameter int unsigned IN_DIM    = 32,
   parameter int unsigned OUT_DIM   = 10,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned WGT_W     = 8,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned IN_SIGNED = 0,
   parameter logic [OUT_DIM*IN_DIM*WGT_W-1:0] W_INIT = '0,
   parameter logic [OUT_DIM*ACC_W-1:0]        B_INIT = '0,
   localparam int unsigned IDX_W = $clog2(OUT_DIM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   output logic [ACC_W-1:0]  out_data_o,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [IDX_W-1:0]  class_out_o,
   output logic [ACC_W-1:0]  class_value_o,
   output logic              class_valid_o,
   output logic              frame_err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_EMIT,
      S_DONE
   } state_e;

   localparam int unsigned CNT_W  = $clog2(IN_DIM);
   localparam int unsigned PROD_W = DATA_W + WGT_W + 1;
   localparam int unsigned SUM_W  = ACC_W + 1;

   localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(IN_DIM - 1);
   localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(OUT_DIM - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        beat_q, beat_d;
   logic signed [ACC_W-1:0] acc_q [OUT_DIM];
   logic signed [ACC_W-1:0] acc_d [OUT_DIM];
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]        max_idx_q, max_idx_d;
   logic signed [ACC_W-1:0] class_value_q, class_value_d;
   logic [IDX_W-1:0]        class_out_q, class_out_d;
   logic                    in_ready_q, in_ready_d;
   logic                    frame_err_q, frame_err_d;

   logic                    accept;
   logic                    last_beat;
   logic                    emit_hs;
   logic                    last_logit;
   logic signed [DATA_W:0]  x_ext;
   logic signed [ACC_W-1:0] cur_logit;

   // One multiply-accumulate step. The sum is one bit wider than the
   // accumulator, so overflow appears as a disagreement between the top two
   // bits. Saturation applies to this step only. A later term can bring the
   // value back into range.
   function automatic logic signed [ACC_W-1:0] mac_sat(
      input logic signed [ACC_W-1:0] base,
      input logic signed [DATA_W:0]  x,
      input logic signed [WGT_W-1:0] w
   );
      logic signed [PROD_W-1:0] prod;
      logic signed [SUM_W-1:0]  sum;
      prod = PROD_W'(x) * PROD_W'(w);
      sum  = SUM_W'(base) + SUM_W'(prod);
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
         mac_sat = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         mac_sat = sum[ACC_W-1:0];
      end
   endfunction

   assign accept     = in_valid_i && in_ready_q;
   assign last_beat  = (beat_q == LAST_BEAT);
   assign emit_hs    = (state_q == S_EMIT) && out_ready_i;
   assign last_logit = (idx_q == LAST_IDX);
   assign cur_logit  = acc_q[idx_q];

   // An extra top bit makes the activation a signed operand in both modes.
   // In unsigned mode the extra bit is always zero.
   assign x_ext = {(IN_SIGNED != 0) && in_data_i[DATA_W-1], in_data_i};

   // NOTE: every _d signal gets its default (hold) value first, so no path
   // through this block can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      max_d         = max_q;
      max_idx_d     = max_idx_q;
      class_value_d = class_value_q;
      class_out_d   = class_out_q;
      frame_err_d   = accept && (in_last_i != last_beat);

      // Beat 0 starts from the bias rather than the previous frame's total.
      if (accept) begin
         for (int j = 0; j < int'(OUT_DIM); j++) begin
            acc_d[j] = mac_sat(
               (beat_q == '0) ? $signed(B_INIT[j*int'(ACC_W) +: ACC_W]) : acc_q[j],
               x_ext,
               $signed(W_INIT[(j*int'(IN_DIM) + int'(beat_q))*int'(WGT_W) +: WGT_W]));
         end
         beat_d = last_beat ? '0 : beat_q + CNT_W'(1);
      end

      // Running max. Index 0 seeds it. After that only a strictly greater
      // signed value replaces it, so ties keep the lowest index.
      if (emit_hs) begin
         idx_d = last_logit ? '0 : idx_q + IDX_W'(1);
         if ((idx_q == '0) || (cur_logit > max_q)) begin
            max_d     = cur_logit;
            max_idx_d = idx_q;
         end
         if (last_logit) begin
            class_value_d = max_d;
            class_out_d   = max_idx_d;
         end
      end

      case (state_q)
         S_IDLE:  if (accept)                 state_d = S_ACC;
         S_ACC:   if (accept && last_beat)    state_d = S_EMIT;
         S_EMIT:  if (emit_hs && last_logit)  state_d = S_DONE;
         S_DONE:                              state_d = S_IDLE;
         default:                             state_d = S_IDLE;
      endcase

      // Registered ready tracks the next state. It therefore stays low while
      // reset is held.
      in_ready_d = (state_d == S_IDLE) || (state_d == S_ACC);
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         beat_q        <= '0;
         idx_q         <= '0;
         max_q         <= '0;
         max_idx_q     <= '0;
         class_value_q <= '0;
         class_out_q   <= '0;
         in_ready_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         // NOTE: the accumulator array is a register file that drives
         // out_data_o directly. It is reset so that no stale logit is
         // visible after an abort.
         for (int j = 0; j < int'(OUT_DIM); j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         max_q         <= max_d;
         max_idx_q     <= max_idx_d;
         class_value_q <= class_value_d;
         class_out_q   <= class_out_d;
         in_ready_q    <= in_ready_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = (state_q == S_EMIT);
   assign out_data_o    = cur_logit;
   assign out_idx_o     = idx_q;
   assign class_valid_o = (state_q == S_DONE);
   assign class_out_o   = class_out_q;
   assign class_value_o = class_value_q;
   assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_fc_argmax_engine.sv
// -----------------------------------------------------------------------------
// tb_fc_argmax_engine
//
// Directed bench for fc_argmax_engine. Three instances carry different weight
// and bias images:
//   0: all weights 1, zero biases, unsigned activations
//   1: zero weights, bias[7] = 100
//   2: signed activations; class 0 w=0x7F b=0x7FFFFFF0, class 1 w=0x80
//      b=0x7FFFFFFF, class 2 w=0x7F b=0x80000000, other classes zero
// 'sel' routes the shared stimulus to one instance and muxes its outputs back.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fc_argmax_engine;

   localparam int unsigned IN_DIM  = 32;
   localparam int unsigned OUT_DIM = 10;
   localparam int unsigned IDX_W   = 4;

   localparam logic [OUT_DIM*IN_DIM*8-1:0] W_ONES = {(OUT_DIM*IN_DIM){8'h01}};
   localparam logic [OUT_DIM*IN_DIM*8-1:0] W_ZERO = '0;
   localparam logic [OUT_DIM*IN_DIM*8-1:0] W_SGN  =
      {{1792{1'b0}}, {32{8'h7F}}, {32{8'h80}}, {32{8'h7F}}};
   localparam logic [OUT_DIM*32-1:0] B_ZERO = '0;
   localparam logic [OUT_DIM*32-1:0] B_B7   = {{2{32'h0}}, 32'd100, {7{32'h0}}};
   localparam logic [OUT_DIM*32-1:0] B_SGN  =
      {{7{32'h0}}, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFF0};

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sel;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;

   logic             in_ready_v    [3];
   logic [31:0]      out_data_v    [3];
   logic [IDX_W-1:0] out_idx_v     [3];
   logic             out_valid_v   [3];
   logic [IDX_W-1:0] class_out_v   [3];
   logic [31:0]      class_value_v [3];
   logic             class_valid_v [3];
   logic             frame_err_v   [3];

   logic             in_ready, out_valid, class_valid, frame_err;
   logic [31:0]      out_data, class_value;
   logic [IDX_W-1:0] out_idx, class_out;

   int          n_tests;
   int          n_fail;
   int          n_ferr;
   int          n_cv;
   int          n_hs;
   int          emit_cyc;
   int          f0;
   int          c0;
   logic [31:0] got   [10];
   logic [31:0] exp_v [10];

   always #5 clk = ~clk;

   fc_argmax_engine #(.IN_SIGNED(0), .W_INIT(W_ONES), .B_INIT(B_ZERO)) dut_a (
      .clk(clk), .rst(rst),
      .in_data_i(in_data), .in_valid_i(in_valid && (sel == 2'd0)), .in_last_i(in_last),
      .in_ready_o(in_ready_v[0]),
      .out_data_o(out_data_v[0]), .out_idx_o(out_idx_v[0]), .out_valid_o(out_valid_v[0]),
      .out_ready_i(out_ready),
      .class_out_o(class_out_v[0]), .class_value_o(class_value_v[0]),
      .class_valid_o(class_valid_v[0]), .frame_err_o(frame_err_v[0])
   );

   fc_argmax_engine #(.IN_SIGNED(0), .W_INIT(W_ZERO), .B_INIT(B_B7)) dut_b (
      .clk(clk), .rst(rst),
      .in_data_i(in_data), .in_valid_i(in_valid && (sel == 2'd1)), .in_last_i(in_last),
      .in_ready_o(in_ready_v[1]),
      .out_data_o(out_data_v[1]), .out_idx_o(out_idx_v[1]), .out_valid_o(out_valid_v[1]),
      .out_ready_i(out_ready),
      .class_out_o(class_out_v[1]), .class_value_o(class_value_v[1]),
      .class_valid_o(class_valid_v[1]), .frame_err_o(frame_err_v[1])
   );

   fc_argmax_engine #(.IN_SIGNED(1), .W_INIT(W_SGN), .B_INIT(B_SGN)) dut_c (
      .clk(clk), .rst(rst),
      .in_data_i(in_data), .in_valid_i(in_valid && (sel == 2'd2)), .in_last_i(in_last),
      .in_ready_o(in_ready_v[2]),
      .out_data_o(out_data_v[2]), .out_idx_o(out_idx_v[2]), .out_valid_o(out_valid_v[2]),
      .out_ready_i(out_ready),
      .class_out_o(class_out_v[2]), .class_value_o(class_value_v[2]),
      .class_valid_o(class_valid_v[2]), .frame_err_o(frame_err_v[2])
   );

   always_comb begin
      in_ready    = in_ready_v[sel];
      out_data    = out_data_v[sel];
      out_idx     = out_idx_v[sel];
      out_valid   = out_valid_v[sel];
      class_out   = class_out_v[sel];
      class_value = class_value_v[sel];
      class_valid = class_valid_v[sel];
      frame_err   = frame_err_v[sel];
   end

   // Pulse counters for the selected instance.
   initial begin
      n_ferr = 0;
      n_cv   = 0;
   end
   always @(posedge clk) begin
      if (frame_err)   n_ferr++;
      if (class_valid) n_cv++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one beat and wait (bounded) until it is accepted.
   task automatic send_beat(input logic [7:0] d, input logic last);
      int guard;
      guard    = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("beat_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d0, input logic [7:0] dn, input int last_at);
      for (int k = 0; k < int'(IN_DIM); k++) begin
         send_beat((k == 0) ? d0 : dn, k == last_at);
      end
   endtask

   // Drain the logit stream, optionally toggling out_ready every cycle.
   task automatic collect(input bit toggle);
      logic [31:0]      prev_data;
      logic [IDX_W-1:0] prev_idx;
      bit               stalled;
      bit               phase;
      prev_data = '0;
      prev_idx  = '0;
      stalled   = 1'b0;
      phase     = 1'b1;
      n_hs      = 0;
      emit_cyc  = 0;
      check("emit_start_valid", {31'b0, out_valid}, 32'd1);
      while (out_valid && emit_cyc < 60) begin
         if (stalled) begin
            check("stall_hold_data", out_data, prev_data);
            check("stall_hold_idx", {28'b0, out_idx}, {28'b0, prev_idx});
         end
         check("emit_in_ready", {31'b0, in_ready}, 32'd0);
         out_ready = toggle ? phase : 1'b1;
         phase     = ~phase;
         if (out_ready) begin
            check("emit_idx_order", {28'b0, out_idx}, n_hs);
            if (n_hs < 10) got[n_hs] = out_data;
            n_hs++;
         end
         stalled   = !out_ready;
         prev_data = out_data;
         prev_idx  = out_idx;
         @(negedge clk);
         emit_cyc++;
      end
      out_ready = 1'b1;
   endtask

   task automatic check_logits(input string tag, input int exp_cycles);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("%s_logit%0d", tag, i), got[i], exp_v[i]);
      end
      check({tag, "_handshakes"}, n_hs, 32'd10);
      check({tag, "_emit_cycles"}, emit_cyc, exp_cycles);
   endtask

   // Called on the falling edge inside the S_DONE cycle.
   task automatic check_class(input string tag, input logic [IDX_W-1:0] ec, input logic [31:0] ev);
      check({tag, "_class_valid"}, {31'b0, class_valid}, 32'd1);
      check({tag, "_class_out"}, {28'b0, class_out}, {28'b0, ec});
      check({tag, "_class_value"}, class_value, ev);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      sel       = 2'd0;
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_idx", {28'b0, out_idx}, 32'd0);
      check("rst_class_valid", {31'b0, class_valid}, 32'd0);
      check("rst_class_out", {28'b0, class_out}, 32'd0);
      check("rst_class_value", class_value, 32'd0);
      check("rst_frame_err", {31'b0, frame_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // All-ones frame: every logit 32, tie resolves to class 0
      f0 = n_ferr;
      c0 = n_cv;
      send_frame(8'h01, 8'h01, 31);
      collect(1'b0);
      exp_v = '{default: 32'd32};
      check_logits("ones", 10);
      check_class("ones", 4'd0, 32'd32);
      @(negedge clk);
      check("ones_class_valid_drop", {31'b0, class_valid}, 32'd0);
      check("ones_idle_in_ready", {31'b0, in_ready}, 32'd1);
      check("ones_frame_err_count", n_ferr - f0, 32'd0);
      check("ones_class_pulses", n_cv - c0, 32'd1);

      // Unsigned mode: 0xFF is +255, so each logit is 32*255
      send_frame(8'hFF, 8'hFF, 31);
      collect(1'b0);
      exp_v = '{default: 32'd8160};
      check_logits("unsigned", 10);
      check_class("unsigned", 4'd0, 32'd8160);

      // Backpressure, back-to-back with the previous frame: out_ready toggles
      send_frame(8'h02, 8'h02, 31);
      collect(1'b1);
      exp_v = '{default: 32'd64};
      check_logits("bp", 19);
      check_class("bp", 4'd0, 32'd64);

      // Framing: in_last on beat 5 and missing on beat 31 give two pulses
      f0 = n_ferr;
      send_frame(8'h01, 8'h01, 5);
      collect(1'b0);
      exp_v = '{default: 32'd32};
      check_logits("frame", 10);
      check_class("frame", 4'd0, 32'd32);
      @(negedge clk);
      check("frame_err_count", n_ferr - f0, 32'd2);

      // Bias only: class 7 wins with 100, twice back-to-back
      sel = 2'd1;
      send_frame(8'h5A, 8'h5A, 31);
      collect(1'b0);
      exp_v    = '{default: 32'd0};
      exp_v[7] = 32'd100;
      check_logits("bias1", 10);
      check_class("bias1", 4'd7, 32'd100);
      send_frame(8'hC3, 8'h3C, 31);
      check("bias_hold_class_out", {28'b0, class_out}, 32'd7);
      check("bias_hold_class_value", class_value, 32'd100);
      collect(1'b0);
      check_logits("bias2", 10);
      check_class("bias2", 4'd7, 32'd100);
      @(negedge clk);

      // Signed mode with saturation at both rails
      sel = 2'd2;
      send_frame(8'h80, 8'h80, 31);
      collect(1'b0);
      exp_v    = '{default: 32'd0};
      exp_v[0] = 32'h7FF8_0FF0;
      exp_v[1] = 32'h7FFF_FFFF;
      exp_v[2] = 32'h8000_0000;
      check_logits("sgn1", 10);
      check_class("sgn1", 4'd1, 32'h7FFF_FFFF);
      // Beat 0 saturates, later beats pull the values back into range
      send_frame(8'h80, 8'h01, 31);
      collect(1'b0);
      exp_v[0] = 32'h7FFF_CFD1;
      exp_v[1] = 32'h7FFF_F07F;
      exp_v[2] = 32'h8000_0F61;
      check_logits("sgn2", 10);
      check_class("sgn2", 4'd1, 32'h7FFF_F07F);
      @(negedge clk);

      // Reset in the middle of the emit phase
      sel = 2'd0;
      send_frame(8'h01, 8'h01, 31);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_pre_idx", {28'b0, out_idx}, 32'd4);
      check("abort_pre_valid", {31'b0, out_valid}, 32'd1);
      c0  = n_cv;
      rst = 1'b1;
      #1;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_out_idx", {28'b0, out_idx}, 32'd0);
      check("abort_out_data", out_data, 32'd0);
      check("abort_class_value", class_value, 32'd0);
      check("abort_class_valid", {31'b0, class_valid}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_class_pulse", n_cv - c0, 32'd0);
      check("abort_idle_valid", {31'b0, out_valid}, 32'd0);
      send_frame(8'h03, 8'h03, 31);
      collect(1'b0);
      exp_v = '{default: 32'd96};
      check_logits("after_abort", 10);
      check_class("after_abort", 4'd0, 32'd96);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_argmax_engine.md
Name: fc_argmax_engine

Overview:
- Parametrised fully-connected layer with streaming logit output and argmax classifier; successor to the fixed 32x10 FC/softmax unit.
- Sits after the last pooling/flatten stage and consumes one activation per accepted beat.
- Computes OUT_DIM dot products plus bias in parallel, then streams logits under backpressure and reports the winning class.
- Adds to the previous generation:
  - generic dimensions and widths
  - signed or unsigned input mode
  - ready/valid on both sides and in_last framing check
  - saturating accumulation
  - correct final argmax with defined tie-break

Parameters:
- IN_DIM, 32, activations per frame (>=2).
- OUT_DIM, 10, number of classes/logits (>=2).
- DATA_W, 8, activation width.
- WGT_W, 8, signed weight width.
- ACC_W, 32, signed accumulator/logit width.
- IN_SIGNED, 0, 1 = activations signed, 0 = unsigned (zero-extended).
- W_FILE, "fc_weights.txt", hex weight image, OUT_DIM*IN_DIM entries, index j*IN_DIM+k.
- B_FILE, "fc_biases.txt", hex bias image, OUT_DIM entries, ACC_W wide.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_data  in  DATA_W  activation k of the current frame.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks activation IN_DIM-1.
- in_ready  out  1  block accepts in_data.
- out_data  out  ACC_W  logit (signed).
- out_idx  out  clog2(OUT_DIM)  class index of out_data.
- out_valid  out  1  logit valid.
- out_ready  in  1  downstream accepts logit.
- class_out  out  clog2(OUT_DIM)  argmax index.
- class_value  out  ACC_W  maximum logit.
- class_valid  out  1  one-cycle pulse, class result valid.
- frame_err  out  1  one-cycle pulse, in_last mismatch.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, accumulators and counters 0. in_ready is 0 during reset and 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts the frame immediately. No partial logits or class are emitted.
- State machine:
  - S_IDLE → S_ACC on first accepted beat.
  - S_ACC → S_EMIT on acceptance of beat IN_DIM-1.
  - S_EMIT → S_DONE when logit OUT_DIM-1 is accepted.
  - S_DONE → S_IDLE after one cycle.
- in_ready = 1 in S_IDLE and S_ACC only; 0 in S_EMIT and S_DONE.
- Accept = in_valid & in_ready.
- Accumulation:
  - On accept of beat k (k = 0..IN_DIM-1), for all j: acc[j] <= (k==0 ? bias[j] : acc[j]) + x*w[j*IN_DIM+k].
  - x is sign- or zero-extended per IN_SIGNED.
  - Product is DATA_W+WGT_W+1 bits, sign-extended to ACC_W+1.
  - Each sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation is sticky per step only: later terms may pull the value back in range.
- Gaps (in_valid low) hold all state.
- Framing: the beat counter alone defines the frame end. frame_err pulses the cycle after an accepted beat where in_last != (k==IN_DIM-1). The frame still completes normally.
- Emit:
  - out_valid rises the cycle after beat IN_DIM-1 is accepted.
  - out_idx starts at 0, with out_data = acc[out_idx].
  - out_valid, out_data and out_idx hold stable while out_ready=0.
  - On out_valid & out_ready, out_idx advances.
  - After index OUT_DIM-1 is accepted, out_valid drops in the next cycle.
- Argmax:
  - Running max is updated on each accepted logit, using a signed compare.
  - Strictly-greater replaces the max, so ties keep the lowest index.
  - class_valid pulses in S_DONE, with class_out/class_value = the final max over all OUT_DIM logits.
  - class_out/class_value hold until the next frame's S_DONE or reset.
- Minimum frame-to-frame time: IN_DIM + OUT_DIM + 1 cycles with out_ready tied high.
- The block never accepts input while emitting; upstream stalls.

Test Plan:
- All weights 1, biases 0, IN_SIGNED=0, 32 beats of 1 with in_last on beat 31, out_ready=1 → 10 logits each 32 on consecutive cycles, idx 0..9; class_valid pulse with class_out=0 and class_value=32 (tie to lowest).
- Bias[7]=100, others 0, weights 0, any input → logits 0,...,100 at idx 7,...; class_out=7, class_value=100. Then a second back-to-back frame gives an identical result with no residue.
- Backpressure: toggle out_ready 1/0 every cycle → each logit held stable while stalled; exactly 10 handshakes; in_ready=0 throughout emit.
- IN_SIGNED=1, in_data=0x80 (-128), weight 0x7F, bias 0x7FFFFFF0 on class 0 → logit 0 = 0x7FFFFFF0 - 128*127*32. Second case with weight -128, in_data=0x80, bias 0x7FFFFFFF → saturates at 0x7FFFFFFF.
- in_last asserted on beat 5 and absent on beat 31 → two frame_err pulses; logits still emitted after beat 31.
- Assert rst for one cycle during emit of idx 4 → all outputs 0 immediately, no class_valid; the next full frame produces correct results.
